instr_fetch_unit: RTL and testbench

Program-counter and instruction-fetch block that feeds the control unit and consumes its redirect outputs (pc_jump, pc_branch, RAM_adr).
- Fetches one 16-bit instruction at a time from instruction memory over a req/ack handshake.
- Presents the instruction to the decoder for one issue slot.
- Computes the next PC: sequential, or redirected to the decoder's target address.
- Sits between instruction memory and the control unit; one outstanding request, no prefetch.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 31 +++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode constants and the fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_JUMP = 4'b1100;
  localparam logic [3:0] OP_BR0  = 4'b1101;
  localparam logic [3:0] OP_BR1  = 4'b1110;
  localparam logic [3:0] OP_BR2  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus; master is the fetch unit, slave is the memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts un-acked FETCH cycles; tc flags the last cycle allowed before giving up.
module fetch_timeout_ctr #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] count_r;

  // Cycle counter; clear wins over enable so a terminal cycle restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = enable & (count_r == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// PC / instruction fetch: one outstanding imem request, one issue slot, redirect on jump/branch.
module instr_fetch_unit #(
  parameter int                ADDR_W        = cpu_pkg::ADDR_W,
  parameter int                INSTR_W       = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC      = {ADDR_W{1'b0}},
  parameter int                FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                pc_jump,
  input  logic                pc_branch,
  input  logic [ADDR_W-1:0]   target_adr,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic                fetch_err,
  output logic [15:0]         retired_cnt
);

  import cpu_pkg::*;

  fetch_state_e       state_r;
  fetch_state_e       state_nxt_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic [15:0]        retired_r;
  logic               fetch_err_r;
  logic               in_fetch_s;
  logic               ack_s;
  logic               tc_s;
  logic               ctr_clear_s;
  logic               ctr_en_s;
  logic               issue_go_s;
  logic               redirect_s;

  assign in_fetch_s  = (state_r == ST_FETCH);
  assign ack_s       = in_fetch_s & imem.imem_ack;
  assign ctr_en_s    = in_fetch_s & ~imem.imem_ack;
  assign ctr_clear_s = ~in_fetch_s | imem.imem_ack | tc_s;
  assign issue_go_s  = (state_r == ST_ISSUE) & ~stall;
  assign redirect_s  = pc_jump | pc_branch;

  fetch_timeout_ctr #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear_s),
    .enable (ctr_en_s),
    .tc     (tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; ack beats timeout on the terminal cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          state_nxt_s = ST_ISSUE;
        end else if (tc_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (stall) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the state register alone so they carry no input paths.
  always_comb begin
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    case (state_r)
      ST_FETCH: imem.imem_req = 1'b1;
      ST_ISSUE: instr_valid   = 1'b1;
      default: begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
      end
    endcase
  end

  // Datapath: PC, captured instruction, retire counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      instr_r     <= {INSTR_W{1'b0}};
      retired_r   <= 16'd0;
      fetch_err_r <= 1'b0;
    end else begin
      fetch_err_r <= tc_s;
      if (ack_s) begin
        instr_r <= imem.imem_rdata;
      end else begin
        instr_r <= instr_r;
      end
      if (issue_go_s) begin
        pc_r      <= redirect_s ? target_adr : pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        retired_r <= retired_r + 16'd1;
      end else begin
        pc_r      <= pc_r;
        retired_r <= retired_r;
      end
    end
  end

  assign imem.imem_addr = pc_r;
  assign instruction    = instr_r;
  assign pc             = pc_r;
  assign fetch_err      = fetch_err_r;
  assign retired_cnt    = retired_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table plus timeout and mid-fetch reset sequences.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    int          lat;
    logic [15:0] rdata;
    int          stall_n;
    logic        jump;
    logic        branch;
    logic [7:0]  target;
    logic [7:0]  exp_next;
    logic [15:0] exp_ret;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_jump;
  logic        pc_branch;
  logic [7:0]  target_adr;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        fetch_err;
  logic [15:0] retired_cnt;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[10];

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .pc_jump     (pc_jump),
    .pc_branch   (pc_branch),
    .target_adr  (target_adr),
    .imem        (imem_bus),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (act=running req=done)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for a request at v.addr, acks after v.lat cycles, then checks the issued word.
  task automatic fetch_cycle(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, imem_bus.imem_addr}, {24'd0, v.addr});
    chk("no_err", {31'd0, fetch_err}, 32'd0);
    for (int i = 0; i < v.lat; i++) begin
      imem_bus.imem_ack = 1'b0;
      @(negedge clk);
      chk("req_hold", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("addr_hold", {24'd0, imem_bus.imem_addr}, {24'd0, v.addr});
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = v.rdata;
    sb.push_back('{pc: v.addr, instr: v.rdata});
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'($urandom);
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("sb_depth", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("issue_instr", {16'd0, instruction}, {16'd0, e.instr});
      chk("issue_pc", {24'd0, pc}, {24'd0, e.pc});
    end
  endtask

  // Holds issue for v.stall_n cycles (with stray acks), then releases with the redirect inputs.
  task automatic do_issue(input vec_t v);
    logic [15:0] held;
    held = instruction;
    for (int s = 0; s < v.stall_n; s++) begin
      stall               = 1'b1;
      pc_jump             = v.jump;
      pc_branch           = v.branch;
      target_adr          = v.target;
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 16'hDEAD;
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {16'd0, instruction}, {16'd0, held});
      chk("stall_pc", {24'd0, pc}, {24'd0, v.addr});
      chk("stall_retired", {16'd0, retired_cnt}, {16'd0, v.exp_ret - 16'd1});
    end
    imem_bus.imem_ack = 1'b0;
    stall             = 1'b0;
    pc_jump           = v.jump;
    pc_branch         = v.branch;
    target_adr        = v.target;
    @(negedge clk);
    pc_jump    = 1'b0;
    pc_branch  = 1'b0;
    target_adr = 8'h00;
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
    chk("next_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("next_addr", {24'd0, imem_bus.imem_addr}, {24'd0, v.exp_next});
    chk("retired", {16'd0, retired_cnt}, {16'd0, v.exp_ret});
  endtask

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail  = 0;
    //         addr  lat rdata                stl jmp   br    tgt    next   ret
    vecs[0] = '{8'h00, 0, {OP_ADD, 12'h001},  0, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    vecs[1] = '{8'h01, 0, {OP_SUB, 12'h012},  0, 1'b0, 1'b0, 8'h00, 8'h02, 16'd2};
    vecs[2] = '{8'h02, 0, {OP_LOAD, 12'h023}, 0, 1'b0, 1'b0, 8'h00, 8'h03, 16'd3};
    vecs[3] = '{8'h03, 0, 16'hC040,           0, 1'b1, 1'b0, 8'h40, 8'h40, 16'd4};
    vecs[4] = '{8'h40, 3, 16'h0900,           0, 1'b0, 1'b0, 8'h00, 8'h41, 16'd5};
    vecs[5] = '{8'h41, 1, {OP_BR0, 12'h080},  2, 1'b0, 1'b1, 8'h80, 8'h80, 16'd6};
    vecs[6] = '{8'h80, 0, {OP_JUMP, 12'h0FF}, 0, 1'b1, 1'b1, 8'hFF, 8'hFF, 16'd7};
    vecs[7] = '{8'hFF, 2, {OP_ADD, 12'h0FF},  0, 1'b0, 1'b0, 8'h00, 8'h00, 16'd8};
    vecs[8] = '{8'h00, 0, {OP_BR1, 12'h010},  0, 1'b1, 1'b1, 8'h10, 8'h10, 16'd9};
    vecs[9] = '{8'h10, 0, {OP_BR2, 12'h011},  1, 1'b0, 1'b0, 8'h33, 8'h11, 16'd10};

    rst_n               = 1'b0;
    stall               = 1'b0;
    pc_jump             = 1'b0;
    pc_branch           = 1'b0;
    target_adr          = 8'h00;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_instr", {16'd0, instruction}, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_addr", {24'd0, imem_bus.imem_addr}, 32'h00);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_retired", {16'd0, retired_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      fetch_cycle(vecs[i]);
      do_issue(vecs[i]);
    end

    // Timeout: 15 un-acked FETCH cycles at 0x11, one IDLE cycle with the error pulse, then refetch.
    for (int i = 0; i < 15; i++) begin
      chk("to_req", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("to_err_low", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
    end
    chk("to_idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("to_err_pulse", {31'd0, fetch_err}, 32'd1);
    chk("to_idle_addr", {24'd0, imem_bus.imem_addr}, 32'h11);
    @(negedge clk);
    chk("to_err_once", {31'd0, fetch_err}, 32'd0);
    chk("to_refetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("to_refetch_addr", {24'd0, imem_bus.imem_addr}, 32'h11);
    v = '{8'h11, 0, {OP_SUB, 12'h111}, 0, 1'b0, 1'b0, 8'h00, 8'h12, 16'd11};
    fetch_cycle(v);
    do_issue(v);

    // Reset asserted mid-FETCH at 0x12; a late ack straddling release must be ignored.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("mid_rst_pc", {24'd0, pc}, 32'h00);
    chk("mid_rst_retired", {16'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    rst_n               = 1'b1;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("late_ack_instr", {16'd0, instruction}, 32'h0);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("post_rst_addr", {24'd0, imem_bus.imem_addr}, 32'h00);
    imem_bus.imem_ack = 1'b0;
    v = '{8'h00, 1, {OP_LOAD, 12'h777}, 0, 1'b0, 1'b0, 8'h00, 8'h01, 16'd1};
    fetch_cycle(v);
    do_issue(v);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
